// File: rtl/orpsoc_sim_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the ORPSoC simulation controller.
package orpsoc_sim_ctrl_pkg;

  localparam logic [15:0] OR1K_NOP_OPC    = 16'h1500;
  localparam logic [15:0] NOP_EXIT_DFLT   = 16'h0001;
  localparam logic [15:0] NOP_REPORT_DFLT = 16'h0002;

  localparam int unsigned MAX_CORES = 8;
  localparam int unsigned CORE_W    = 3;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CORE_W-1:0] core;
  } core_evt_t;

  // Index of the lowest set bit; zero when nothing is set.
  function automatic logic [CORE_W-1:0] first_set(input logic [MAX_CORES-1:0] vec);
    first_set = '0;
    for (int i = int'(MAX_CORES) - 1; i >= 0; i--) begin
      if (vec[i]) first_set = CORE_W'(i);
    end
  endfunction

  function automatic logic multi_set(input logic [MAX_CORES-1:0] vec);
    return (vec & (vec - MAX_CORES'(1))) != '0;
  endfunction

endpackage

// File: rtl/orpsoc_rst_stretch.sv
// Reset stretcher: synchronises rst_n release and holds sys_rst_n low for RST_CYCLES clocks.
module orpsoc_rst_stretch #(
  parameter int unsigned RST_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  output logic sys_rst_n,
  output logic run_start_c
);

  localparam int unsigned CNT_W = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] REL_CNT = CNT_W'(RST_CYCLES - 2);

  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;

  // The release flop acts as the second synchroniser stage.
  assign run_start_c = sync_q && !sys_rst_n && (cnt_q == REL_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 1'b0;
      cnt_q     <= '0;
      sys_rst_n <= 1'b0;
    end else begin
      sync_q <= 1'b1;
      if (sync_q && !sys_rst_n) cnt_q <= cnt_q + CNT_W'(1);
      if (run_start_c) sys_rst_n <= 1'b1;
    end
  end

endmodule

// File: rtl/orpsoc_sim_ctrl.sv
// Reset sequencer, cycle watchdog and l.nop end-of-test detector for multi-core benches.
module orpsoc_sim_ctrl
  import orpsoc_sim_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 1,
  parameter int unsigned TIMEOUT_W  = 32,
  parameter int unsigned RST_CYCLES = 20,
  parameter logic [15:0] NOP_EXIT   = NOP_EXIT_DFLT,
  parameter logic [15:0] NOP_REPORT = NOP_REPORT_DFLT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TIMEOUT_W-1:0]   timeout_i,
  input  logic [NUM_CORES-1:0]   insn_valid_i,
  input  logic [32*NUM_CORES-1:0] insn_i,
  input  logic [32*NUM_CORES-1:0] gpr3_i,
  output logic                   sys_rst_n_o,
  output logic                   running_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   timeout_o,
  output logic [31:0]            exit_code_o,
  output logic [2:0]             exit_core_o,
  output logic                   report_valid_o,
  output logic [31:0]            report_data_o,
  output logic [2:0]             report_core_o,
  output logic                   report_lost_o,
  output logic [TIMEOUT_W-1:0]   cycles_o
);

  logic                 run_start_c;
  logic [MAX_CORES-1:0] exit_hit;
  logic [MAX_CORES-1:0] report_hit;
  logic [DATA_W-1:0]    gpr3 [MAX_CORES];
  logic [CORE_W-1:0]    exit_idx;
  logic [CORE_W-1:0]    report_idx;
  logic                 timeout_hit;

  state_e               state_q, state_d;
  core_evt_t            exit_q, exit_d, report_q, report_d;
  logic                 running_d, done_d, pass_d, timeout_d;
  logic                 report_valid_d, report_lost_d;
  logic [TIMEOUT_W-1:0] cycles_d;

  orpsoc_rst_stretch #(
    .RST_CYCLES (RST_CYCLES)
  ) u_rst_stretch (
    .clk         (clk),
    .rst_n       (rst_n),
    .sys_rst_n   (sys_rst_n_o),
    .run_start_c (run_start_c)
  );

  // Per-core l.nop decode; unused channels read as idle.
  always_comb begin
    exit_hit   = '0;
    report_hit = '0;
    for (int k = 0; k < int'(MAX_CORES); k++) gpr3[k] = '0;
    for (int k = 0; k < int'(NUM_CORES); k++) begin
      gpr3[k] = gpr3_i[32*k +: 32];
      if (insn_valid_i[k] && (insn_i[32*k+16 +: 16] == OR1K_NOP_OPC)) begin
        exit_hit[k]   = (insn_i[32*k +: 16] == NOP_EXIT);
        report_hit[k] = (insn_i[32*k +: 16] == NOP_REPORT);
      end
    end
  end

  assign exit_idx    = first_set(exit_hit);
  assign report_idx  = first_set(report_hit);
  assign timeout_hit = (timeout_i != '0) && (cycles_o == timeout_i - TIMEOUT_W'(1));

  // Next state and next values of every registered output.
  always_comb begin
    state_d        = state_q;
    running_d      = running_o;
    done_d         = done_o;
    pass_d         = pass_o;
    timeout_d      = timeout_o;
    exit_d         = exit_q;
    report_d       = report_q;
    report_valid_d = 1'b0;
    report_lost_d  = report_lost_o;
    cycles_d       = cycles_o;

    case (state_q)
      ST_RESET: begin
        if (run_start_c) begin
          state_d   = ST_RUN;
          running_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (cycles_o != '1) cycles_d = cycles_o + TIMEOUT_W'(1);
        if (report_hit != '0) begin
          report_valid_d = 1'b1;
          report_d       = '{data: gpr3[report_idx], core: report_idx};
          if (multi_set(report_hit)) report_lost_d = 1'b1;
        end
        // An exit in the watchdog's final cycle still wins.
        if (exit_hit != '0) begin
          state_d   = ST_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
          exit_d    = '{data: gpr3[exit_idx], core: exit_idx};
          pass_d    = (gpr3[exit_idx] == '0);
        end else if (timeout_hit) begin
          state_d   = ST_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RESET;
      running_o      <= 1'b0;
      done_o         <= 1'b0;
      pass_o         <= 1'b0;
      timeout_o      <= 1'b0;
      exit_q         <= '0;
      report_q       <= '0;
      report_valid_o <= 1'b0;
      report_lost_o  <= 1'b0;
      cycles_o       <= '0;
    end else begin
      state_q        <= state_d;
      running_o      <= running_d;
      done_o         <= done_d;
      pass_o         <= pass_d;
      timeout_o      <= timeout_d;
      exit_q         <= exit_d;
      report_q       <= report_d;
      report_valid_o <= report_valid_d;
      report_lost_o  <= report_lost_d;
      cycles_o       <= cycles_d;
    end
  end

  assign exit_code_o   = exit_q.data;
  assign exit_core_o   = exit_q.core;
  assign report_data_o = report_q.data;
  assign report_core_o = report_q.core;

endmodule

// File: tb/tb_orpsoc_sim_ctrl.sv
// Self-checking bench for orpsoc_sim_ctrl: vector table, directed corner sequences, random runs.
module tb_orpsoc_sim_ctrl;

  localparam int unsigned NC = 4;
  localparam int unsigned TW = 32;
  localparam int unsigned RC = 20;
  localparam logic [31:0] EXIT_W = 32'h1500_0001;
  localparam logic [31:0] RPT_W  = 32'h1500_0002;
  localparam logic [31:0] NONE_W = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [TW-1:0] timeout;
  logic [NC-1:0] iv;
  logic [32*NC-1:0] insn, gpr3;
  logic          sys_rst_n, running, done, pass, tmo, rv, lost;
  logic [31:0]   code, rdata;
  logic [2:0]    core, rcore;
  logic [TW-1:0] cycles;

  logic [7:0]    timeout1;
  logic [0:0]    iv1;
  logic [31:0]   insn1, gpr31;
  logic          sys1, running1, done1, pass1, tmo1, rv1, lost1;
  logic [31:0]   code1, rdata1;
  logic [2:0]    core1, rcore1;
  logic [7:0]    cycles1;

  always #5 clk = ~clk;

  orpsoc_sim_ctrl #(.NUM_CORES(NC), .TIMEOUT_W(TW), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .timeout_i(timeout), .insn_valid_i(iv), .insn_i(insn),
    .gpr3_i(gpr3), .sys_rst_n_o(sys_rst_n), .running_o(running), .done_o(done),
    .pass_o(pass), .timeout_o(tmo), .exit_code_o(code), .exit_core_o(core),
    .report_valid_o(rv), .report_data_o(rdata), .report_core_o(rcore),
    .report_lost_o(lost), .cycles_o(cycles)
  );

  orpsoc_sim_ctrl #(.NUM_CORES(1), .TIMEOUT_W(8), .RST_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .timeout_i(timeout1), .insn_valid_i(iv1), .insn_i(insn1),
    .gpr3_i(gpr31), .sys_rst_n_o(sys1), .running_o(running1), .done_o(done1),
    .pass_o(pass1), .timeout_o(tmo1), .exit_code_o(code1), .exit_core_o(core1),
    .report_valid_o(rv1), .report_data_o(rdata1), .report_core_o(rcore1),
    .report_lost_o(lost1), .cycles_o(cycles1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state for the 4-core instance.
  int          m_rel;
  bit          m_run, m_done, m_pass, m_tmo, m_rv, m_lost;
  logic [31:0] m_code, m_rdata, m_cycles;
  logic [2:0]  m_core, m_rcore;

  typedef struct packed {
    logic [NC-1:0]       iv;
    logic [NC-1:0][31:0] insn;
    logic [NC-1:0][31:0] r3;
    logic                done;
    logic                pass;
    logic [31:0]         code;
    logic [2:0]          core;
    logic                rv;
    logic [31:0]         rdata;
    logic [2:0]          rcore;
    logic                lost;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rel = 0; m_run = 0; m_done = 0; m_pass = 0; m_tmo = 0; m_rv = 0; m_lost = 0;
    m_code = '0; m_rdata = '0; m_cycles = '0; m_core = '0; m_rcore = '0;
  endtask

  // Effect of the coming clock edge, from the behavioural rules.
  task automatic model_edge();
    int ex, rp, nrp;
    logic [31:0] w;
    bit hit_tmo;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_rv = 1'b0;
    if (m_run) begin
      ex = -1; rp = -1; nrp = 0;
      for (int k = 0; k < int'(NC); k++) begin
        if (iv[k]) begin
          w = insn[32*k +: 32];
          if (w == EXIT_W && ex < 0) ex = k;
          if (w == RPT_W) begin
            nrp++;
            if (rp < 0) rp = k;
          end
        end
      end
      if (rp >= 0) begin
        m_rv = 1'b1; m_rdata = gpr3[32*rp +: 32]; m_rcore = 3'(rp);
        if (nrp > 1) m_lost = 1'b1;
      end
      hit_tmo = (timeout != '0) && (64'(m_cycles) + 64'd1 == 64'(timeout));
      if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
      if (ex >= 0) begin
        m_run = 0; m_done = 1; m_code = gpr3[32*ex +: 32]; m_core = 3'(ex);
        m_pass = (m_code == 32'd0);
      end else if (hit_tmo) begin
        m_run = 0; m_done = 1; m_tmo = 1; m_pass = 0;
      end
    end else if (!m_done) begin
      m_rel++;
      if (m_rel >= int'(RC)) m_run = 1;
    end
  endtask

  task automatic check_all();
    chk("sys_rst_n", 32'(sys_rst_n), 32'(m_rel >= int'(RC)));
    chk("running", 32'(running), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("pass", 32'(pass), 32'(m_pass));
    chk("timeout", 32'(tmo), 32'(m_tmo));
    chk("exit_code", code, m_code);
    chk("exit_core", 32'(core), 32'(m_core));
    chk("report_valid", 32'(rv), 32'(m_rv));
    chk("report_data", rdata, m_rdata);
    chk("report_core", 32'(rcore), 32'(m_rcore));
    chk("report_lost", 32'(lost), 32'(m_lost));
    chk("cycles", cycles, m_cycles);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    iv = '0; insn = '0; gpr3 = '0;
  endtask

  task automatic rand_inputs();
    int r;
    for (int k = 0; k < int'(NC); k++) begin
      r = int'($urandom_range(199, 0));
      if (r == 0)       insn[32*k +: 32] = EXIT_W;
      else if (r <= 10) insn[32*k +: 32] = RPT_W;
      else if (r <= 13) insn[32*k +: 32] = 32'h1500_0003;
      else if (r <= 16) insn[32*k +: 32] = 32'h1400_0001;
      else              insn[32*k +: 32] = $urandom;
      gpr3[32*k +: 32] = ($urandom_range(1, 0) == 0) ? 32'd0 : $urandom;
    end
    iv = NC'($urandom);
  endtask

  // Assert rst_n between clock edges and check the asynchronous clear.
  task automatic assert_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
  endtask

  task automatic start_run(input bit noisy);
    assert_reset();
    for (int i = 0; i < 3; i++) begin
      if (noisy) rand_inputs();
      step();
    end
    rst_n = 1'b1;
    for (int i = 0; i < int'(RC); i++) begin
      if (noisy) rand_inputs();
      step();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; timeout = '0; timeout1 = '0;
    iv1 = '0; insn1 = '0; gpr31 = '0;
    idle_inputs();
    model_reset();

    vecs[0] = '{iv: 4'b0001, insn: {NONE_W, NONE_W, NONE_W, EXIT_W}, r3: {32'd0, 32'd0, 32'd0, 32'd0},
                done: 1, pass: 1, code: 32'd0, core: 3'd0, rv: 0, rdata: 32'd0, rcore: 3'd0, lost: 0};
    vecs[1] = '{iv: 4'b1010, insn: {EXIT_W, NONE_W, EXIT_W, NONE_W}, r3: {32'd0, 32'd0, 32'd5, 32'd0},
                done: 1, pass: 0, code: 32'd5, core: 3'd1, rv: 0, rdata: 32'd0, rcore: 3'd0, lost: 0};
    vecs[2] = '{iv: 4'b0101, insn: {NONE_W, RPT_W, NONE_W, RPT_W}, r3: {32'd0, 32'hBB, 32'd0, 32'hAA},
                done: 0, pass: 0, code: 32'd0, core: 3'd0, rv: 1, rdata: 32'hAA, rcore: 3'd0, lost: 1};
    vecs[3] = '{iv: 4'b1100, insn: {RPT_W, EXIT_W, NONE_W, NONE_W}, r3: {32'h77, 32'd0, 32'd0, 32'd0},
                done: 1, pass: 1, code: 32'd0, core: 3'd2, rv: 1, rdata: 32'h77, rcore: 3'd3, lost: 0};
    vecs[4] = '{iv: 4'b0000, insn: {EXIT_W, EXIT_W, RPT_W, EXIT_W}, r3: {32'd9, 32'd9, 32'd9, 32'd9},
                done: 0, pass: 0, code: 32'd0, core: 3'd0, rv: 0, rdata: 32'd0, rcore: 3'd0, lost: 0};
    vecs[5] = '{iv: 4'b1111, insn: {RPT_W, 32'h1501_0001, 32'h1400_0001, 32'h1500_0003},
                r3: {32'h1234, 32'd0, 32'd0, 32'd0},
                done: 0, pass: 0, code: 32'd0, core: 3'd0, rv: 1, rdata: 32'h1234, rcore: 3'd3, lost: 0};
    vecs[6] = '{iv: 4'b1000, insn: {EXIT_W, NONE_W, NONE_W, NONE_W}, r3: {32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0},
                done: 1, pass: 0, code: 32'hFFFF_FFFF, core: 3'd3, rv: 0, rdata: 32'd0, rcore: 3'd0, lost: 0};
    vecs[7] = '{iv: 4'b1110, insn: {RPT_W, RPT_W, RPT_W, NONE_W}, r3: {32'd3, 32'd2, 32'd1, 32'd0},
                done: 0, pass: 0, code: 32'd0, core: 3'd0, rv: 1, rdata: 32'd1, rcore: 3'd1, lost: 1};
    vecs[8] = '{iv: 4'b0001, insn: {EXIT_W, EXIT_W, EXIT_W, RPT_W}, r3: {32'd0, 32'd0, 32'd0, 32'h55},
                done: 0, pass: 0, code: 32'd0, core: 3'd0, rv: 1, rdata: 32'h55, rcore: 3'd0, lost: 0};

    // Reset held 10 cycles, then release timing of both instances.
    @(negedge clk);
    check_all();
    chk("rst_sys", 32'(sys_rst_n), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b1;
    for (int i = 1; i <= int'(RC); i++) begin
      step();
      if (i == 1) chk("d1_sys_edge1", 32'(sys1), 32'd0);
      if (i == 2) begin
        chk("d1_sys_edge2", 32'(sys1), 32'd1);
        chk("d1_running_edge2", 32'(running1), 32'd1);
      end
      if (i == int'(RC) - 1) chk("sys_edge19", 32'(sys_rst_n), 32'd0);
      if (i == int'(RC)) begin
        chk("sys_edge20", 32'(sys_rst_n), 32'd1);
        chk("running_edge20", 32'(running), 32'd1);
        chk("cycles_start", cycles, 32'd0);
      end
    end

    // Single-core exit with code 0 in RUN cycle 100.
    for (int i = 0; i < 99; i++) step();
    chk("t100_pre_done", 32'(done), 32'd0);
    iv = 4'b0001; insn[31:0] = EXIT_W; gpr3[31:0] = 32'd0;
    step();
    idle_inputs();
    chk("t100_done", 32'(done), 32'd1);
    chk("t100_pass", 32'(pass), 32'd1);
    chk("t100_core", 32'(core), 32'd0);
    chk("t100_cycles", cycles, 32'd100);
    chk("t100_running", 32'(running), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("t100_cycles_frozen", cycles, 32'd100);

    // Reset after done, then reset in the middle of RUN.
    assert_reset();
    chk("rst_after_done_done", 32'(done), 32'd0);
    chk("rst_after_done_pass", 32'(pass), 32'd0);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    for (int i = 0; i < int'(RC) + 30; i++) step();
    chk("mid_pre_cycles", cycles, 32'd30);
    assert_reset();
    chk("mid_sys", 32'(sys_rst_n), 32'd0);
    chk("mid_running", 32'(running), 32'd0);
    chk("mid_cycles", cycles, 32'd0);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    for (int i = 0; i < int'(RC); i++) step();
    chk("mid_restart_cycles", cycles, 32'd0);
    chk("mid_restart_running", 32'(running), 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("mid_restart_cycles5", cycles, 32'd5);

    // Watchdog at 50.
    timeout = 32'd50;
    start_run(1'b0);
    for (int i = 0; i < 49; i++) step();
    chk("tmo50_pre_done", 32'(done), 32'd0);
    step();
    chk("tmo50_done", 32'(done), 32'd1);
    chk("tmo50_timeout", 32'(tmo), 32'd1);
    chk("tmo50_pass", 32'(pass), 32'd0);
    chk("tmo50_cycles", cycles, 32'd50);

    // No limit for 10000 cycles; the 8-bit instance saturates meanwhile.
    timeout = '0;
    start_run(1'b0);
    for (int i = 0; i < 10000; i++) step();
    chk("tmo0_done", 32'(done), 32'd0);
    chk("tmo0_cycles", cycles, 32'd10000);
    chk("d1_sat_cycles", 32'(cycles1), 32'd255);
    chk("d1_sat_done", 32'(done1), 32'd0);
    chk("d1_sat_running", 32'(running1), 32'd1);
    timeout = 32'd10;
    for (int i = 0; i < 20; i++) step();
    chk("tmo_lowered_done", 32'(done), 32'd0);

    // Exit in the last watchdog cycle.
    timeout = 32'd30;
    start_run(1'b0);
    for (int i = 0; i < 29; i++) step();
    iv = 4'b0001; insn[31:0] = EXIT_W; gpr3[31:0] = 32'd0;
    step();
    idle_inputs();
    chk("edge_exit_done", 32'(done), 32'd1);
    chk("edge_exit_timeout", 32'(tmo), 32'd0);
    chk("edge_exit_pass", 32'(pass), 32'd1);
    chk("edge_exit_cycles", cycles, 32'd30);

    // Table of single-cycle decode patterns, each from a fresh reset.
    timeout = '0;
    for (int v = 0; v < 9; v++) begin
      idle_inputs();
      start_run(1'b0);
      iv = vecs[v].iv; insn = vecs[v].insn; gpr3 = vecs[v].r3;
      step();
      idle_inputs();
      chk($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].done));
      chk($sformatf("vec%0d_pass", v), 32'(pass), 32'(vecs[v].pass));
      chk($sformatf("vec%0d_code", v), code, vecs[v].code);
      chk($sformatf("vec%0d_core", v), 32'(core), 32'(vecs[v].core));
      chk($sformatf("vec%0d_rv", v), 32'(rv), 32'(vecs[v].rv));
      chk($sformatf("vec%0d_rdata", v), rdata, vecs[v].rdata);
      chk($sformatf("vec%0d_rcore", v), 32'(rcore), 32'(vecs[v].rcore));
      chk($sformatf("vec%0d_lost", v), 32'(lost), 32'(vecs[v].lost));
      step();
      chk($sformatf("vec%0d_rv_pulse", v), 32'(rv), 32'd0);
      chk($sformatf("vec%0d_done_sticky", v), 32'(done), 32'(vecs[v].done));
    end

    // Random runs against the model; the first also times out the 8-bit instance.
    for (int r = 0; r < 20; r++) begin
      timeout = ($urandom_range(3, 0) == 0) ? 32'd0 : 32'($urandom_range(200, 1));
      if (r == 0) timeout1 = 8'hFF;
      start_run(1'b1);
      for (int c = 0; c < 300; c++) begin
        rand_inputs();
        if ($urandom_range(49, 0) == 0) timeout = 32'($urandom_range(200, 0));
        step();
      end
      if (r == 0) begin
        chk("d1_tmo_done", 32'(done1), 32'd1);
        chk("d1_tmo_timeout", 32'(tmo1), 32'd1);
        chk("d1_tmo_pass", 32'(pass1), 32'd0);
        chk("d1_tmo_cycles", 32'(cycles1), 32'd255);
        chk("d1_tmo_running", 32'(running1), 32'd0);
        chk("d1_code", code1, 32'd0);
        chk("d1_core", 32'(core1), 32'd0);
        chk("d1_rv", 32'(rv1), 32'd0);
        chk("d1_rdata", rdata1, 32'd0);
        chk("d1_rcore", 32'(rcore1), 32'd0);
        chk("d1_lost", 32'(lost1), 32'd0);
        chk("d1_sys", 32'(sys1), 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
